// File: rtl/trivium_byte_xor.sv
// Keystream consumer for the trivium generator: skips warm-up, packs bits MSB-first into a
// small byte FIFO, and XORs buffered keystream bytes into a valid/ready byte stream.
module trivium_byte_xor #(
   parameter int WARMUP     = 1152,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic       ks_en,
   input  logic       ks_bit,
   output logic       ks_ready,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {WARM = 1'b0, RUN = 1'b1} state_t;

   state_t          state_r;
   logic [10:0]     warm_cnt_r;
   logic [2:0]      pulse_pos_r;
   logic [CW-1:0]   reserved_r;
   logic            sample_r;
   logic [6:0]      shreg_r;
   logic [2:0]      bit_cnt_r;
   logic [7:0]      mem_r [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   fifo_count_r;

   logic            push_s;
   logic            pop_s;
   logic            last_pulse_s;
   logic [CW-1:0]   reserved_nxt_s;

   // FIFO handshake decode; reserved counts bytes whose 8th pulse has issued but are not yet popped,
   // so the enable stops exactly when every slot is spoken for, even while a byte is still in flight
   always_comb begin
      in_ready       = (fifo_count_r != {CW{1'b0}}) && (!out_valid || out_ready);
      push_s         = sample_r && (bit_cnt_r == 3'd7);
      pop_s          = in_valid && in_ready;
      last_pulse_s   = ks_en && (state_r == RUN) && (pulse_pos_r == 3'd7);
      reserved_nxt_s = reserved_r + CW'(last_pulse_s) - CW'(pop_s);
   end

   // Warm-up / run sequencing and generator enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= WARM;
         warm_cnt_r  <= 11'd0;
         ks_en       <= 1'b0;
         ks_ready    <= 1'b0;
         pulse_pos_r <= 3'd0;
         reserved_r  <= {CW{1'b0}};
      end else begin
         case (state_r)
            WARM: begin
               ks_en <= 1'b1;
               if (ks_en) begin
                  warm_cnt_r <= warm_cnt_r + 11'd1;
                  if (warm_cnt_r == 11'(WARMUP - 1)) begin
                     state_r  <= RUN;
                     ks_ready <= 1'b1;
                  end
               end
            end
            RUN: begin
               ks_en      <= (reserved_nxt_s < CW'(FIFO_DEPTH));
               reserved_r <= reserved_nxt_s;
               if (ks_en) begin
                  pulse_pos_r <= pulse_pos_r + 3'd1;
               end
            end
            default: state_r <= WARM;
         endcase
      end
   end

   // Bit packer and keystream byte FIFO; warm-up pulses never raise the sample strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_r     <= 1'b0;
         shreg_r      <= 7'd0;
         bit_cnt_r    <= 3'd0;
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         fifo_count_r <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'd0;
         end
      end else begin
         sample_r <= ks_en && (state_r == RUN);
         if (sample_r) begin
            shreg_r   <= {shreg_r[5:0], ks_bit};
            bit_cnt_r <= bit_cnt_r + 3'd1;
         end
         if (push_s) begin
            mem_r[wr_ptr_r] <= {shreg_r, ks_bit};
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         fifo_count_r <= fifo_count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Ciphertext output register; data holds while the sink stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data  <= 8'd0;
         out_valid <= 1'b0;
      end else if (pop_s) begin
         out_data  <= in_data ^ mem_r[rd_ptr_r];
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trivium_byte_xor.sv
// Self-checking bench: models the keystream generator as a random bit table and predicts
// each ciphertext byte as plaintext XOR the next unused 8-bit keystream slice.
module tb_trivium_byte_xor;

   localparam int WARMUP = 1152;
   localparam int DEPTH  = 4;
   localparam int NBITS  = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bit   bits [NBITS];
   int   checks   = 0;
   int   failures = 0;
   int   kb_idx   = 0;
   logic rt_mode  = 1'b0;

   logic       a_ks_en, a_ks_bit, a_ks_ready, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0] a_in_data, a_out_data;
   logic       tb_out_ready;
   logic       b_ks_en, b_ks_bit, b_ks_ready, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0] b_in_data, b_out_data;
   int         a_idx, b_idx;

   assign a_out_ready = rt_mode ? b_in_ready : tb_out_ready;
   assign b_in_data   = a_out_data;
   assign b_in_valid  = rt_mode & a_out_valid;

   trivium_byte_xor dut (
      .clk(clk), .rst(rst), .ks_en(a_ks_en), .ks_bit(a_ks_bit), .ks_ready(a_ks_ready),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready));

   trivium_byte_xor dut_b (
      .clk(clk), .rst(rst), .ks_en(b_ks_en), .ks_bit(b_ks_bit), .ks_ready(b_ks_ready),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready));

   // generator models: one table bit per enable pulse, output registered
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_idx <= 0; a_ks_bit <= 1'b0;
      end else if (a_ks_en) begin
         a_ks_bit <= bits[a_idx % NBITS]; a_idx <= a_idx + 1;
      end
   end
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         b_idx <= 0; b_ks_bit <= 1'b0;
      end else if (b_ks_en) begin
         b_ks_bit <= bits[b_idx % NBITS]; b_idx <= b_idx + 1;
      end
   end

   function automatic logic [7:0] ks_byte(input int k);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = bits[WARMUP + 8*k + i];
      return r;
   endfunction

   task automatic do_reset(input bit fill, input bit pat);
      logic [7:0] p;
      @(negedge clk);
      rst = 1'b0; a_in_valid = 1'b0; a_in_data = 8'd0; tb_out_ready = 1'b1; b_out_ready = 1'b0;
      if (fill) for (int i = 0; i < NBITS; i++) bits[i] = 1'($urandom);
      if (pat) begin
         p = 8'hB2;
         for (int i = 0; i < 8; i++) bits[WARMUP + i] = p[7-i];
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      kb_idx = 0;
   endtask

   task automatic wait_full(output bit ok);
      int c = 0;
      ok = 1'b0;
      while (!ok && c < 3000) begin
         @(negedge clk); #1; c++;
         if (a_ks_ready && !a_ks_en) ok = 1'b1;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      checks++;
      if ({a_ks_en, a_ks_ready, a_in_ready, a_out_valid, a_out_data} !== 12'd0) begin
         failures++;
         $display("FAIL reset_values: got en=%b rdy=%b in_rdy=%b ov=%b od=%h, want all 0",
                  a_ks_en, a_ks_ready, a_in_ready, a_out_valid, a_out_data);
      end
   endtask

   task automatic test_warmup();
      int cyc = 0, warm = 0, first_en = -1, rdy_cyc = -1, runp = 0;
      bit done = 1'b0, en_at_rdy = 1'b0, held = 1'b1;
      do_reset(1'b1, 1'b0);
      while (!done && cyc < 3000) begin
         @(negedge clk); #1; cyc++;
         if (a_ks_en && first_en < 0) first_en = cyc;
         if (!a_ks_ready) begin
            if (a_ks_en) warm++;
         end else begin
            if (rdy_cyc < 0) begin rdy_cyc = cyc; en_at_rdy = a_ks_en; end
            if (a_ks_en) runp++; else done = 1'b1;
         end
      end
      checks++;
      if (warm != WARMUP) begin failures++; $display("FAIL warm_pulses: got %0d want %0d", warm, WARMUP); end
      checks++;
      if (rdy_cyc - first_en != WARMUP) begin
         failures++; $display("FAIL ready_timing: got %0d cycles want %0d", rdy_cyc - first_en, WARMUP);
      end
      checks++;
      if (en_at_rdy !== 1'b1) begin failures++; $display("FAIL en_continues: got %b want 1", en_at_rdy); end
      checks++;
      if (runp != 8*DEPTH) begin failures++; $display("FAIL fill_pulses: got %0d want %0d", runp, 8*DEPTH); end
      repeat (5) begin
         @(negedge clk); #1;
         if (a_ks_en !== 1'b0) held = 1'b0;
      end
      checks++;
      if (!held) begin failures++; $display("FAIL full_en_low: ks_en rose while full, want 0"); end
      checks++;
      if (dut.fifo_count_r !== 3'd4) begin
         failures++; $display("FAIL full_count: got %0d want 4", dut.fifo_count_r);
      end
   endtask

   task automatic test_fifo_full();
      logic [7:0] pt = 8'($urandom);
      int pulses = 0;
      @(negedge clk);
      a_in_data = pt; a_in_valid = 1'b1; tb_out_ready = 1'b1; #1;
      checks++;
      if (a_in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready: got %b want 1", a_in_ready); end
      @(negedge clk);
      a_in_valid = 1'b0; #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== (pt ^ ks_byte(kb_idx))) begin
         failures++; $display("FAIL full_xor: got v=%b d=%h want v=1 d=%h", a_out_valid, a_out_data, pt ^ ks_byte(kb_idx));
      end
      kb_idx++;
      for (int i = 0; i < 30; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         if (a_ks_en) pulses++;
      end
      checks++;
      if (pulses != 8) begin failures++; $display("FAIL refill_pulses: got %0d want 8", pulses); end
   endtask

   task automatic test_packing();
      bit ok;
      do_reset(1'b1, 1'b1);
      wait_full(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL pack_timeout: got no full FIFO want full"); end
      @(negedge clk);
      a_in_data = 8'hFF; a_in_valid = 1'b1; tb_out_ready = 1'b1; #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         failures++; $display("FAIL pack_pre: got ov=%b ir=%b want ov=0 ir=1", a_out_valid, a_in_ready);
      end
      @(negedge clk);
      a_in_valid = 1'b0; #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 8'h4D) begin
         failures++; $display("FAIL pack_xor: got v=%b d=%h want v=1 d=4d", a_out_valid, a_out_data);
      end
      kb_idx = 1;
   endtask

   task automatic test_backpressure();
      logic [7:0] exp0, cur_exp, d1;
      bit ok;
      wait_full(ok);
      @(negedge clk);
      a_in_data = 8'($urandom); a_in_valid = 1'b1; tb_out_ready = 1'b0; #1;
      checks++;
      if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready: got %b want 1", a_in_ready); end
      exp0 = a_in_data ^ ks_byte(kb_idx); kb_idx++;
      d1 = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_in_data = d1; #1;
         checks++;
         if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== exp0) begin
            failures++;
            $display("FAIL bp_hold: got ir=%b ov=%b od=%h want ir=0 ov=1 od=%h", a_in_ready, a_out_valid, a_out_data, exp0);
         end
      end
      cur_exp = exp0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tb_out_ready = 1'b1;
         if (i > 0) a_in_data = 8'($urandom);
         #1;
         checks++;
         if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out_data !== cur_exp) begin
            failures++;
            $display("FAIL bp_stream: got ir=%b ov=%b od=%h want ir=1 ov=1 od=%h", a_in_ready, a_out_valid, a_out_data, cur_exp);
         end
         cur_exp = a_in_data ^ ks_byte(kb_idx); kb_idx++;
      end
      @(negedge clk);
      a_in_valid = 1'b0; #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== cur_exp) begin
         failures++; $display("FAIL bp_last: got ov=%b od=%h want ov=1 od=%h", a_out_valid, a_out_data, cur_exp);
      end
      @(negedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got ov=%b want 0", a_out_valid); end
   endtask

   task automatic test_round_trip();
      logic [7:0] pt [64];
      int sent = 0, arecv = 0, recv = 0, c = 0;
      bit acc = 1'b0;
      rt_mode = 1'b1;
      for (int i = 0; i < 64; i++) pt[i] = 8'($urandom);
      do_reset(1'b1, 1'b0);
      while (recv < 64 && c < 6000) begin
         @(negedge clk);
         c++;
         if (acc) begin a_in_valid = 1'b0; acc = 1'b0; end
         if (!a_in_valid && sent < 64 && $urandom_range(0, 3) != 0) begin
            a_in_valid = 1'b1; a_in_data = pt[sent];
         end
         b_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (a_in_valid && a_in_ready) begin sent++; acc = 1'b1; end
         if (a_out_valid && a_out_ready) begin
            checks++;
            if (a_out_data !== (pt[arecv] ^ ks_byte(arecv))) begin
               failures++; $display("FAIL rt_cipher[%0d]: got %h want %h", arecv, a_out_data, pt[arecv] ^ ks_byte(arecv));
            end
            arecv++;
         end
         if (b_out_valid && b_out_ready) begin
            checks++;
            if (b_out_data !== pt[recv]) begin
               failures++; $display("FAIL rt_plain[%0d]: got %h want %h", recv, b_out_data, pt[recv]);
            end
            recv++;
         end
      end
      checks++;
      if (recv != 64) begin failures++; $display("FAIL rt_count: got %0d want 64", recv); end
      @(negedge clk);
      a_in_valid = 1'b0; b_out_ready = 1'b0; rt_mode = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int c = 0, warm = 0;
      bit hit = 1'b0, ok;
      logic [7:0] pt = 8'($urandom);
      do_reset(1'b1, 1'b0);
      while (!hit && c < 3000) begin
         @(negedge clk); #1; c++;
         if (dut.fifo_count_r == 3'd2 && dut.bit_cnt_r == 3'd3) hit = 1'b1;
      end
      checks++;
      if (!hit) begin failures++; $display("FAIL mid_reach: got no 2-byte/3-bit point want reached"); end
      @(negedge clk);
      rst = 1'b0; #1;
      checks++;
      if ({a_ks_en, a_ks_ready, a_in_ready, a_out_valid, a_out_data} !== 12'd0 ||
          dut.fifo_count_r !== 3'd0 || dut.bit_cnt_r !== 3'd0) begin
         failures++; $display("FAIL mid_clear: got en=%b rdy=%b ir=%b ov=%b od=%h cnt=%0d bits=%0d want all 0",
                              a_ks_en, a_ks_ready, a_in_ready, a_out_valid, a_out_data, dut.fifo_count_r, dut.bit_cnt_r);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1; kb_idx = 0; c = 0;
      while (!a_ks_ready && c < 3000) begin
         @(negedge clk); #1; c++;
         if (a_ks_en && !a_ks_ready) warm++;
      end
      checks++;
      if (warm != WARMUP) begin failures++; $display("FAIL mid_warm: got %0d want %0d", warm, WARMUP); end
      wait_full(ok);
      @(negedge clk);
      a_in_data = pt; a_in_valid = 1'b1; tb_out_ready = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0; #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== (pt ^ ks_byte(0))) begin
         failures++; $display("FAIL mid_first_byte: got v=%b d=%h want v=1 d=%h", a_out_valid, a_out_data, pt ^ ks_byte(0));
      end
   endtask

   initial begin
      a_in_valid = 1'b0; a_in_data = 8'd0; tb_out_ready = 1'b1; b_out_ready = 1'b0;
      #2 rst = 1'b0;
      test_reset();
      test_warmup();
      test_fifo_full();
      test_packing();
      test_backpressure();
      test_round_trip();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
